serial_deserializer: RTL and testbench
======================================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter BITS, default 8: frame width in bits; legal range is 2 to 32.
REQ-002 Port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port SI, input, 1 bit: serial data from the upstream shift register, LSB first.
REQ-005 Port Start, input, 1 bit: frame-start strobe, sampled together with bit 0 of SI.
REQ-006 Port Ready, input, 1 bit: consumer accepts data_out when Ready=1 and Valid=1.
REQ-007 Port data_out, output, BITS bits: last completed frame.
REQ-008 Port Valid, output, 1 bit: data_out holds an unaccepted frame.
REQ-009 Port Busy, output, 1 bit: a frame is being shifted in.
REQ-010 Port Overrun, output, 1 bit: sticky flag, set when a completed frame was dropped.

Function
REQ-011 The FSM SHALL have two states: IDLE (Busy=0) and SHIFT (Busy=1).
REQ-012 In IDLE, Start=1 at an edge SHALL capture SI as bit 0, set the bit counter to 1 and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL shift SI into the MSB of the internal register (right shift) and increment the counter.
REQ-014 On the edge that captures bit BITS-1 (the BITS-th edge counting from the Start edge), the FSM SHALL return to IDLE and the assembled word SHALL complete.
REQ-015 Each completed word SHALL transfer to the data_out holding register, and Valid=1, on that same edge, unless REQ-018 applies.
REQ-016 Start SHALL be ignored while in SHIFT; SI SHALL be ignored while in IDLE with Start=0.
REQ-017 Valid SHALL stay 1 with data_out stable until an edge with Ready=1; Valid SHALL then clear on that edge, unless REQ-019 applies.
REQ-018 If a word completes while Valid=1 and Ready=0, the word SHALL be discarded, data_out SHALL remain unchanged, and Overrun SHALL be set.
REQ-019 If a word completes while Valid=1 and Ready=1, data_out SHALL load the new word and Valid SHALL remain 1, with no overrun.
REQ-020 Overrun SHALL remain 1 until RST.
REQ-021 Start=1 on the edge immediately after completion SHALL begin a new frame, giving back-to-back frames with no idle cycle.
REQ-022 The bit counter SHALL be $clog2(BITS)+1 bits wide and SHALL never wrap within a frame.

Reset
REQ-023 RST=1 SHALL immediately force: state IDLE, counter 0, shift register 0, data_out 0, Valid 0, Busy 0, Overrun 0.
REQ-024 RST asserted mid-frame SHALL abort the frame with no partial word emitted.
REQ-025 After RST is released, the first frame SHALL start only on a fresh Start strobe.

Structure
REQ-026 State encodings (IDLE=0, SHIFT=1) and the default BITS SHALL live in the shared constants package/header used by the register modules.
REQ-027 The serial-in/parallel-out datapath SHALL be a sub-module named sipo_shift (BITS-wide right shift with enable); the FSM, counter and output buffer SHALL stay in serial_deserializer.

Verification
REQ-028 The bench SHALL cover the following directed scenarios, with BITS=8 and the upstream LSB-first stream driven on SI.
REQ-029 Basic frame: RST, then Start with stream 8'h0A -> after the 8th edge, data_out=8'h0A, Valid=1, Busy=0, Overrun=0.
REQ-030 Overrun: hold Ready=0, send 8'h5C after 8'h0A -> data_out stays 8'h0A, Valid=1, Overrun=1.
REQ-031 Back-to-back with accept: 8'h0A then 8'h5C, with Ready=1 on the completion edge of 8'h5C -> data_out=8'h5C, Valid=1, Overrun=0.
REQ-032 Stray Start: pulse Start at bit 3 of 8'hA5 -> frame unaffected, data_out=8'hA5 after the 8th edge.
REQ-033 Mid-frame reset: RST after 4 bits -> all outputs 0 immediately; next frame 8'hFF yields data_out=8'hFF, Valid=1.

Source files
------------

// File: rtl/serial_deserializer_pkg.sv
// Shared constants for the serial deserializer.
// Holds the FSM encoding, the default frame width and a counter-width helper.
package serial_deserializer_pkg;

    localparam int DEFAULT_BITS = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int bits);
        return $clog2(bits) + 1;
    endfunction

endpackage

// File: rtl/serial_deserializer_sipo.sv
// Serial-in / parallel-out right shift register.
// New bits enter at the MSB so an LSB-first stream lands in order after BITS shifts.
module sipo_shift #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            si,
    output logic [BITS-1:0] word
);

    logic [BITS-1:0] q;

    // word is the register contents as they will be after this edge's shift
    assign word = {si, q[BITS-1:1]};

    // the oldest bit falls off the bottom and is never observed
    logic unused_lsb;
    assign unused_lsb = q[0];

    // shift one bit in at the MSB whenever enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= word;
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Frame-level deserializer: Start-strobed LSB-first capture into a
// single-entry output buffer with valid/ready handoff and sticky overrun.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            SI,
    input  logic            Start,
    input  logic            Ready,
    output logic [BITS-1:0] data_out,
    output logic            Valid,
    output logic            Busy,
    output logic            Overrun
);

    localparam int CW = cnt_width(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    if (BITS < 2 || BITS > 32) begin : g_bits_check
        $error("serial_deserializer: BITS must be in 2..32");
    end

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            shift_en;
    logic            done;
    logic [BITS-1:0] word;

    sipo_shift #(
        .BITS (BITS)
    ) u_sipo (
        .clk  (CLK),
        .rst  (RST),
        .en   (shift_en),
        .si   (SI),
        .word (word)
    );

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state: Start opens a frame, the last bit closes it
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // outputs of the FSM: busy flag, shift enable and frame completion
    always_comb begin
        Busy     = 1'b0;
        shift_en = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                shift_en = Start;
            end
            SHIFT: begin
                Busy     = 1'b1;
                shift_en = 1'b1;
                done     = (cnt == LAST);
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    // bit counter: 1 after the Start edge, cleared when the frame completes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            if (Start) cnt <= CW'(1);
        end else if (done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // output buffer: load on completion unless a held word would be lost
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_out <= '0;
            Valid    <= 1'b0;
            Overrun  <= 1'b0;
        end else if (done) begin
            if (Valid && !Ready) begin
                Overrun <= 1'b1;
            end else begin
                data_out <= word;
                Valid    <= 1'b1;
            end
        end else if (Ready) begin
            Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer (BITS=8): directed frames plus
// random serial traffic compared against a frame-level reference model.
module tb_serial_deserializer;

    localparam int BITS = 8;

    logic            CLK = 1'b0;
    logic            RST;
    logic            SI;
    logic            Start;
    logic            Ready;
    logic [BITS-1:0] data_out;
    logic            Valid;
    logic            Busy;
    logic            Overrun;

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    // reference model state
    bit              mb;
    bit              mv;
    bit              movr;
    logic [BITS-1:0] md;
    bit              mq[$];
    logic [BITS-1:0] sbq[$];

    serial_deserializer #(
        .BITS (BITS)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SI       (SI),
        .Start    (Start),
        .Ready    (Ready),
        .data_out (data_out),
        .Valid    (Valid),
        .Busy     (Busy),
        .Overrun  (Overrun)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input logic [7:0] d,
                              input logic v, input logic b, input logic o);
        chk({nm, "_data"}, 32'(data_out), 32'(d));
        chk({nm, "_valid"}, 32'(Valid), 32'(v));
        chk({nm, "_busy"}, 32'(Busy), 32'(b));
        chk({nm, "_overrun"}, 32'(Overrun), 32'(o));
    endtask

    // frame-level model: collect bits, assemble LSB-first, apply buffer rules
    always @(posedge CLK or posedge RST) begin : model
        logic [BITS-1:0] w;
        bit fin;
        bit acc;
        if (RST) begin
            mv   <= 1'b0;
            md   <= '0;
            movr <= 1'b0;
            mb   <= 1'b0;
            mq.delete();
            sbq.delete();
        end else begin
            fin = 1'b0;
            w   = '0;
            acc = mv && Ready;
            if (mb) begin
                mq.push_back(SI);
                if (mq.size() == BITS) begin
                    fin = 1'b1;
                    for (int i = 0; i < BITS; i++) w[i] = mq[i];
                    mq.delete();
                    mb <= 1'b0;
                end
            end else if (Start) begin
                mq.delete();
                mq.push_back(SI);
                mb <= 1'b1;
            end
            if (acc) sbq.push_back(md);
            if (fin) begin
                if (mv && !Ready) begin
                    movr <= 1'b1;
                end else begin
                    md <= w;
                    mv <= 1'b1;
                end
            end else if (acc) begin
                mv <= 1'b0;
            end
        end
    end

    // monitor: every accepted word must match the next scoreboard entry
    always @(posedge CLK) begin : monitor
        logic [BITS-1:0] got;
        if (!RST && Valid && Ready) begin
            got = data_out;
            #1;
            if (sbq.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL accept_unexpected: got word %0h, expected none", got);
            end else begin
                chk("accept_data", 32'(got), 32'(sbq.pop_front()));
            end
        end
    end

    // per-cycle comparison of all outputs against the model
    always @(negedge CLK) begin
        if (chk_en && !RST) begin
            chk("cyc_data", 32'(data_out), 32'(md));
            chk("cyc_valid", 32'(Valid), 32'(mv));
            chk("cyc_busy", 32'(Busy), 32'(mb));
            chk("cyc_overrun", 32'(Overrun), 32'(movr));
        end
    end

    task automatic send_frame(input logic [7:0] w, input int stray,
                              input bit rb, input bit rl);
        for (int i = 0; i < BITS; i++) begin
            @(negedge CLK);
            Start = (i == 0) || (i == stray);
            SI    = w[i];
            Ready = (i == BITS - 1) ? rl : rb;
        end
    endtask

    task automatic idle(input bit r);
        @(negedge CLK);
        Start = 1'b0;
        SI    = 1'($urandom_range(0, 1));
        Ready = r;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        expect_out("reset_pulse", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int rate;
        RST   = 1'b1;
        Start = 1'b0;
        SI    = 1'b0;
        Ready = 1'b0;
        #1;
        expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST    = 1'b0;
        chk_en = 1'b1;

        send_frame(8'h0A, -1, 1'b0, 1'b0);
        idle(1'b0);
        expect_out("basic", 8'h0A, 1'b1, 1'b0, 1'b0);

        send_frame(8'h5C, -1, 1'b0, 1'b0);
        idle(1'b0);
        expect_out("overrun", 8'h0A, 1'b1, 1'b0, 1'b1);

        pulse_reset();

        send_frame(8'h0A, -1, 1'b0, 1'b0);
        send_frame(8'h5C, -1, 1'b0, 1'b1);
        idle(1'b0);
        expect_out("b2b_accept", 8'h5C, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        expect_out("accept_clear", 8'h5C, 1'b0, 1'b0, 1'b0);

        send_frame(8'hA5, 3, 1'b0, 1'b0);
        idle(1'b0);
        expect_out("stray_start", 8'hA5, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            Start = (i == 0);
            SI    = 1'b1;
            Ready = 1'b0;
        end
        @(negedge CLK);
        Start = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        expect_out("midframe_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        SI  = 1'b1;
        idle(1'b0);
        chk("no_restart_busy", 32'(Busy), 32'(0));
        send_frame(8'hFF, -1, 1'b0, 1'b0);
        idle(1'b0);
        expect_out("after_rst", 8'hFF, 1'b1, 1'b0, 1'b0);

        for (int seg = 0; seg < 4; seg++) begin
            pulse_reset();
            rate = (seg % 2 == 0) ? 90 : 35;
            for (int c = 0; c < 500; c++) begin
                @(negedge CLK);
                Start = ($urandom_range(0, 3) == 0);
                SI    = 1'($urandom_range(0, 1));
                Ready = ($urandom_range(0, 99) < rate);
            end
        end

        for (int c = 0; c < 3; c++) idle(1'b0);
        chk("scoreboard_drain", 32'(sbq.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
